// File: rtl/wb_pkg.sv
// Shared writeback-stage types.
//   WB_WIDTH     : datapath width of each writeback candidate
//   WB_SELW      : width of the writeback select code
//   wb_sel_t     : writeback mux select (ALU / load / PC+2 / immediate)
//   wb_entry_t   : one MEM->WB payload (four candidates plus select)
//   skid_state_t : occupancy of the MEM->WB skid register
package wb_pkg;

  localparam int WB_WIDTH = 64;
  localparam int WB_SELW  = 2;

  typedef enum logic [WB_SELW-1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC  = 2'd2,
    WB_IMM = 2'd3
  } wb_sel_t;

  typedef struct packed {
    logic [WB_WIDTH-1:0] a;
    logic [WB_WIDTH-1:0] b;
    logic [WB_WIDTH-1:0] c;
    logic [WB_WIDTH-1:0] d;
    wb_sel_t             sel;
  } wb_entry_t;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_ONE,
    ST_FULL
  } skid_state_t;

endpackage

// File: rtl/wb_entry_reg.sv
// Load-enabled register holding one packed writeback entry.
//   clk, rst_n : clock, asynchronous active-low reset (clears contents to 0)
//   load       : capture d on the next rising edge
//   d, q       : packed entry in / registered entry out (4*WIDTH+SELW bits)
module wb_entry_reg
  import wb_pkg::*;
#(
  parameter int WIDTH = WB_WIDTH,
  parameter int SELW  = WB_SELW
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*WIDTH+SELW-1:0] d,
  output logic [4*WIDTH+SELW-1:0] q
);

  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/wb_skid_reg.sv
// MEM->WB pipeline register with a 2-entry skid buffer feeding the writeback
// 4:1 select mux. Valid/ready on both sides; in_ready comes straight from the
// skid-valid flop so WB back-pressure never reaches MEM combinationally.
//   clk, rst_n           : clock, asynchronous active-low reset
//   flush                : synchronous kill of all buffered entries
//   in_valid / in_ready  : upstream handshake
//   in_a..in_d, in_sel   : ALU result, load data, PC+2, immediate, select
//   out_valid / out_ready: downstream handshake
//   out_a..out_d, out_sel: registered candidates and select to the WB mux
module wb_skid_reg
  import wb_pkg::*;
#(
  parameter int WIDTH = WB_WIDTH,
  parameter int SELW  = WB_SELW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_c,
  input  logic [WIDTH-1:0] in_d,
  input  logic [SELW-1:0]  in_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [WIDTH-1:0] out_c,
  output logic [WIDTH-1:0] out_d,
  output logic [SELW-1:0]  out_sel
);

  logic        main_valid, skid_valid;
  logic        main_valid_n, skid_valid_n;
  logic        main_load, skid_load, main_from_skid;
  logic        in_xfer, out_xfer;
  skid_state_t state;
  wb_entry_t   in_entry, main_d, main_q, skid_q;

  assign in_entry = '{a: in_a, b: in_b, c: in_c, d: in_d, sel: wb_sel_t'(in_sel)};

  assign in_ready  = !skid_valid;
  assign out_valid = main_valid;
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = main_valid && out_ready;

  // The skid only ever fills behind a valid main entry, so two flops encode
  // the three occupancy states.
  assign state = skid_valid ? ST_FULL : (main_valid ? ST_ONE : ST_EMPTY);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else begin
      main_valid <= main_valid_n;
      skid_valid <= skid_valid_n;
    end
  end

  // NOTE: every output of this block gets a default first, so no branch can
  // leave one unassigned and infer a latch.
  always_comb begin
    main_valid_n   = main_valid;
    skid_valid_n   = skid_valid;
    main_load      = 1'b0;
    skid_load      = 1'b0;
    main_from_skid = 1'b0;
    if (flush) begin
      // Only the valid bits drop; payload registers keep their contents.
      main_valid_n = 1'b0;
      skid_valid_n = 1'b0;
    end else begin
      unique case (state)
        ST_EMPTY: begin
          if (in_xfer) begin
            main_load    = 1'b1;
            main_valid_n = 1'b1;
          end
        end
        ST_ONE: begin
          if (in_xfer && out_xfer) begin
            main_load = 1'b1;
          end else if (in_xfer) begin
            skid_load    = 1'b1;
            skid_valid_n = 1'b1;
          end else if (out_xfer) begin
            main_valid_n = 1'b0;
          end
        end
        ST_FULL: begin
          // in_ready is low here, so only the drain case exists.
          if (out_xfer) begin
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_valid_n   = 1'b0;
          end
        end
        default: begin
          main_valid_n = 1'b0;
          skid_valid_n = 1'b0;
        end
      endcase
    end
  end

  assign main_d = main_from_skid ? skid_q : in_entry;

  wb_entry_reg #(.WIDTH(WIDTH), .SELW(SELW)) u_main (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (main_load),
    .d     (main_d),
    .q     (main_q)
  );

  wb_entry_reg #(.WIDTH(WIDTH), .SELW(SELW)) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (skid_load),
    .d     (in_entry),
    .q     (skid_q)
  );

  assign out_a   = main_q.a;
  assign out_b   = main_q.b;
  assign out_c   = main_q.c;
  assign out_d   = main_q.d;
  assign out_sel = main_q.sel;

endmodule

// File: tb/tb_wb_skid_reg.sv
// Directed and scoreboarded bench for wb_skid_reg.
module tb_wb_skid_reg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_a, in_b, in_c, in_d;
  logic [1:0]  in_sel;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_a, out_b, out_c, out_d;
  logic [1:0]  out_sel;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  wb_skid_reg dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_c      (in_c),
    .in_d      (in_d),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_a     (out_a),
    .out_b     (out_b),
    .out_c     (out_c),
    .out_d     (out_d),
    .out_sel   (out_sel)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [63:0] a, input logic [1:0] s);
    in_valid = v;
    in_a     = a;
    in_b     = a ^ 64'h0000_0000_0000_0B0B;
    in_c     = a ^ 64'h0000_0000_00C0_0000;
    in_d     = a ^ 64'hD000_0000_0000_0000;
    in_sel   = s;
  endtask

  typedef struct {
    logic [63:0] a;
    logic [1:0]  sel;
  } sb_t;

  initial begin
    sb_t q[$];
    sb_t e;
    int  sent, rcvd;
    logic ix, ox;

    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 64'h0, 2'd0);
    #1;
    check("rst_out_valid", {63'h0, out_valid}, 64'd0);
    check("rst_in_ready",  {63'h0, in_ready},  64'd1);
    check("rst_out_a",     out_a,              64'd0);
    check("rst_out_sel",   {62'h0, out_sel},   64'd0);
    step(); step();
    rst_n = 1'b1;

    // Pass-through: one-cycle latency when empty.
    out_ready = 1'b1;
    drive(1'b1, 64'h11, 2'd2);
    step();
    check("pt_out_valid", {63'h0, out_valid}, 64'd1);
    check("pt_out_a",     out_a,              64'h11);
    check("pt_out_sel",   {62'h0, out_sel},   64'd2);
    drive(1'b0, 64'h0, 2'd0);
    step();
    check("pt_drained", {63'h0, out_valid}, 64'd0);

    // Back-pressure: X then Y with out_ready low.
    out_ready = 1'b0;
    drive(1'b1, 64'hAA, 2'd1);
    step();
    check("bp_x_out_a",    out_a,             64'hAA);
    check("bp_x_in_ready", {63'h0, in_ready}, 64'd1);
    drive(1'b1, 64'hBB, 2'd3);
    step();
    check("bp_y_out_a",    out_a,             64'hAA);
    check("bp_y_in_ready", {63'h0, in_ready}, 64'd0);
    drive(1'b0, 64'h0, 2'd0);
    step();
    check("bp_hold_out_a", out_a,              64'hAA);
    check("bp_hold_valid", {63'h0, out_valid}, 64'd1);
    out_ready = 1'b1;
    step();
    check("bp_drain_y_a",   out_a,              64'hBB);
    check("bp_drain_y_sel", {62'h0, out_sel},   64'd3);
    check("bp_drain_rdy",   {63'h0, in_ready},  64'd1);
    step();
    check("bp_empty", {63'h0, out_valid}, 64'd0);

    // Select sweep at full throughput.
    for (int s = 0; s < 4; s++) begin
      drive(1'b1, 64'h100 + 64'(s), 2'(s));
      step();
      check($sformatf("sel%0d_sel", s), {62'h0, out_sel}, 64'(s));
      check($sformatf("sel%0d_a", s), out_a, 64'h100 + 64'(s));
      check($sformatf("sel%0d_b", s), out_b, (64'h100 + 64'(s)) ^ 64'h0B0B);
      check($sformatf("sel%0d_c", s), out_c, (64'h100 + 64'(s)) ^ 64'h00C0_0000);
      check($sformatf("sel%0d_d", s), out_d, (64'h100 + 64'(s)) ^ 64'hD000_0000_0000_0000);
    end
    drive(1'b0, 64'h0, 2'd0);
    step();

    // Flush while full, with simultaneous input and output handshakes.
    out_ready = 1'b0;
    drive(1'b1, 64'h50, 2'd0);
    step();
    drive(1'b1, 64'h51, 2'd1);
    step();
    check("fl_full_in_ready", {63'h0, in_ready}, 64'd0);
    flush = 1'b1; out_ready = 1'b1;
    drive(1'b1, 64'h52, 2'd2);
    step();
    check("fl_out_valid", {63'h0, out_valid}, 64'd0);
    check("fl_in_ready",  {63'h0, in_ready},  64'd1);
    check("fl_data_kept", out_a,              64'h50);
    flush = 1'b0;
    drive(1'b0, 64'h0, 2'd0);
    step();
    check("fl_stays_empty", {63'h0, out_valid}, 64'd0);
    drive(1'b1, 64'h53, 2'd3);
    step();
    check("fl_resume_a", out_a, 64'h53);
    drive(1'b0, 64'h0, 2'd0);
    step();

    // Streaming with random gaps and back-pressure, checked against a queue.
    sent = 0; rcvd = 0;
    for (int cyc = 0; cyc < 3000 && rcvd < 100; cyc++) begin
      drive((sent < 100) && ($urandom_range(0, 1) == 1),
            {$urandom, $urandom}, 2'($urandom_range(0, 3)));
      out_ready = ($urandom_range(0, 1) == 1);
      ix = in_valid && in_ready;
      ox = out_valid && out_ready;
      if (ox) begin
        if (q.size() == 0) begin
          check("stream_spurious", {63'h0, ox}, 64'd0);
        end else begin
          e = q.pop_front();
          check("stream_a",   out_a,            e.a);
          check("stream_sel", {62'h0, out_sel}, {62'h0, e.sel});
          rcvd++;
        end
      end
      if (ix) begin
        e.a = in_a; e.sel = in_sel;
        q.push_back(e);
        sent++;
      end
      step();
    end
    check("stream_count", 64'(rcvd), 64'd100);
    check("stream_left",  64'(q.size()), 64'd0);
    drive(1'b0, 64'h0, 2'd0);
    out_ready = 1'b1;
    step();

    // Asynchronous reset while full.
    out_ready = 1'b0;
    drive(1'b1, 64'h77, 2'd1);
    step();
    drive(1'b1, 64'h78, 2'd2);
    step();
    drive(1'b0, 64'h0, 2'd0);
    check("ar_pre_in_ready", {63'h0, in_ready}, 64'd0);
    #2 rst_n = 1'b0;
    #1;
    check("ar_out_valid", {63'h0, out_valid}, 64'd0);
    check("ar_in_ready",  {63'h0, in_ready},  64'd1);
    check("ar_out_a",     out_a,              64'd0);
    check("ar_out_sel",   {62'h0, out_sel},   64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
